// File: rtl/pipeline_flush_ctrl_pkg.sv
// Shared opcodes and controller state encoding for the pipeline flush/stall controller.
package pipeline_flush_ctrl_pkg;

    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FLUSH = 2'd1,
        STALL = 2'd2
    } state_e;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/pipeline_flush_ctrl_sat_counter.sv
// Saturating event counter: counts inc pulses, frozen while hold is high, sticks at all-ones.
// 1-cycle update latency; no backpressure.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         hold,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc && !hold && (count_q != {W{1'b1}})) begin
            count_d = count_q + W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/pipeline_flush_ctrl.sv
// Redirect flush and load-use stall controller between EX and the IF/ID, ID/EX registers.
// Responds combinationally in the event cycle, registered continuation for the rest; hold freezes state.
module pipeline_flush_ctrl
    import pipeline_flush_ctrl_pkg::*;
#(
    parameter int XLEN         = 32,
    parameter int REG_W        = 5,
    parameter int FLUSH_CYCLES = 2,
    parameter int LOAD_STALL   = 1,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [XLEN-1:0]  ex_instr,
    input  logic             ex_valid,
    input  logic             branch_result,
    input  logic             ex_is_load,
    input  logic [REG_W-1:0] ex_rd,
    input  logic [REG_W-1:0] id_rs1,
    input  logic [REG_W-1:0] id_rs2,
    input  logic             hold,
    output logic             nop_enable,
    output logic             redirect,
    output logic             stall,
    output logic             bubble,
    output logic [CNT_W-1:0] flush_count,
    output logic [CNT_W-1:0] stall_count
);

    localparam int MAXC = max_int(FLUSH_CYCLES, LOAD_STALL);
    localparam int CW   = $clog2(MAXC + 1);
    localparam logic [CW-1:0] FLUSH_RELOAD = CW'(FLUSH_CYCLES - 1);
    localparam logic [CW-1:0] STALL_RELOAD = CW'(LOAD_STALL - 1);
    localparam logic          FLUSH_MULTI  = (FLUSH_CYCLES > 1);
    localparam logic          STALL_MULTI  = (LOAD_STALL > 1);

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic [6:0] opcode;
    logic       is_jump;
    logic       is_branch;
    logic       redirect_evt;
    logic       hazard_evt;

    logic       nop_c, redirect_c, stall_c;
    logic       take_redirect, take_hazard;

    assign opcode       = ex_instr[6:0];
    assign is_jump      = (opcode == OP_JAL) || (opcode == OP_JALR);
    assign is_branch    = (opcode == OP_BRANCH);
    assign redirect_evt = ex_valid && (is_jump || (is_branch && branch_result));
    assign hazard_evt   = ex_valid && ex_is_load && (ex_rd != '0) &&
                          ((ex_rd == id_rs1) || (ex_rd == id_rs2));

    // FLUSH ignores events: the instructions sitting in EX are already squashed.
    always_comb begin
        nop_c         = 1'b0;
        redirect_c    = 1'b0;
        stall_c       = 1'b0;
        take_redirect = 1'b0;
        take_hazard   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (redirect_evt) begin
                    nop_c         = 1'b1;
                    redirect_c    = 1'b1;
                    take_redirect = 1'b1;
                end else if (hazard_evt) begin
                    stall_c     = 1'b1;
                    take_hazard = 1'b1;
                end
            end
            FLUSH: begin
                nop_c = 1'b1;
            end
            STALL: begin
                if (redirect_evt) begin
                    nop_c         = 1'b1;
                    redirect_c    = 1'b1;
                    take_redirect = 1'b1;
                end else begin
                    stall_c = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (!hold) begin
            unique case (state_q)
                IDLE: begin
                    if (take_redirect && FLUSH_MULTI) begin
                        state_d = FLUSH;
                        cnt_d   = FLUSH_RELOAD;
                    end else if (take_hazard && STALL_MULTI) begin
                        state_d = STALL;
                        cnt_d   = STALL_RELOAD;
                    end
                end
                FLUSH: begin
                    if (cnt_q == CW'(1)) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q - CW'(1);
                    end
                end
                STALL: begin
                    if (take_redirect) begin
                        state_d = FLUSH_MULTI ? FLUSH : IDLE;
                        cnt_d   = FLUSH_MULTI ? FLUSH_RELOAD : '0;
                    end else if (cnt_q == CW'(1)) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q - CW'(1);
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Combinational outputs are gated so nothing leaks out while reset is held.
    assign nop_enable = nop_c && !rst;
    assign redirect   = redirect_c && !rst;
    assign stall      = stall_c && !rst;
    assign bubble     = stall_c && !rst;

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (take_redirect),
        .hold  (hold),
        .count (flush_count)
    );

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (take_hazard),
        .hold  (hold),
        .count (stall_count)
    );

endmodule

// File: doc/pipeline_flush_ctrl.md
# pipeline_flush_ctrl

Parametrised hazard and flush controller for the RISC-V 5-stage pipeline; successor to the single-cycle NOP generator. It decodes the EX-stage instruction for JAL/JALR and taken conditional branches and holds the fetch/decode flush for a configurable number of cycles. It also detects load-use hazards and stalls the front end for a configurable number of cycles. A memory-wait hold and saturating flush/stall event counters are included. Sits between the EX stage and the IF/ID and ID/EX pipeline registers.

## Interface
- XLEN, 32, instruction width; opcode is always bits [6:0]
- REG_W, 5, register address width
- FLUSH_CYCLES, 2, cycles nop_enable is asserted per redirect (≥1)
- LOAD_STALL, 1, cycles stall is asserted per load-use hazard (≥1)
- CNT_W, 16, width of event counters
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- ex_instr  in  XLEN  instruction currently in EX
- ex_valid  in  1  ex_instr is a real instruction, not a bubble
- branch_result  in  1  branch comparator outcome for ex_instr
- ex_is_load  in  1  ex_instr is a load
- ex_rd  in  REG_W  destination of ex_instr
- id_rs1, id_rs2  in  REG_W  sources of the instruction in ID
- hold  in  1  memory wait; freezes controller state
- nop_enable  out  1  flush IF/ID (insert NOP)
- redirect  out  1  select branch/jump target as next PC
- stall  out  1  freeze PC and IF/ID
- bubble  out  1  insert NOP into ID/EX
- flush_count, stall_count  out  CNT_W  saturating event counters

## Operation
- Decode: jump = opcode 1101111 (JAL) or 1100111 (JALR); branch = opcode 1100011. Full 7-bit match.
- redirect_evt = ex_valid & (jump | (branch & branch_result)).
- hazard_evt = ex_valid & ex_is_load & ex_rd≠0 & (ex_rd==id_rs1 | ex_rd==id_rs2).
- FSM states: IDLE, FLUSH, STALL. Down-counter cnt, width clog2(max(FLUSH_CYCLES,LOAD_STALL)+1).
- IDLE:
  - On redirect_evt: nop_enable=1 and redirect=1 in the same cycle.
  - If FLUSH_CYCLES>1, go to FLUSH with cnt=FLUSH_CYCLES-1.
  - Otherwise, if no redirect_evt and hazard_evt: stall=1 and bubble=1. If LOAD_STALL>1, go to STALL with cnt=LOAD_STALL-1.
- FLUSH: nop_enable=1, redirect=0. Decrement cnt; at cnt==1, next state is IDLE. redirect_evt and hazard_evt are ignored, because EX holds squashed instructions.
- STALL: stall=1 and bubble=1. Decrement cnt; return to IDLE at cnt==1. If redirect_evt occurs, it wins: behave as IDLE-redirect (nop_enable, redirect, load FLUSH) and abort the stall.
- Priority: redirect over hazard, always.
- hold=1: state, cnt and counters are frozen. Outputs are recomputed from the current state. In IDLE, events are still decoded but do not advance state.
- Counters:
  - flush_count increments once per accepted redirect_evt.
  - stall_count increments once per accepted hazard_evt.
  - Both saturate at 2^CNT_W-1 and never wrap.

## Timing
- Reset: state IDLE, cnt 0, counters 0. All outputs are 0 while rst=1, including the combinational outputs, which are gated.
- Event response: 0-cycle (combinational) in the event cycle. Registered continuation covers the following N-1 cycles.
- A redirect produces exactly FLUSH_CYCLES nop_enable cycles and exactly 1 redirect cycle, excluding hold cycles.
- A hazard produces exactly LOAD_STALL stall/bubble cycles, excluding hold cycles.
- Reset asserted mid-FLUSH/STALL: outputs drop immediately and the state returns to IDLE. No residual cycles remain after release.

## Structure
- A shared package holds:
  - opcode constants OP_JAL, OP_JALR, OP_BRANCH
  - state enum {IDLE, FLUSH, STALL}
- Sub-module sat_counter (parameter W; inputs inc, hold; async reset) is instantiated twice, for flush_count and stall_count.

## Test plan
- JAL (0x0000006F), ex_valid=1, FLUSH_CYCLES=2 -> nop_enable high 2 cycles, redirect high 1 cycle, flush_count=1.
- BEQ (0x00000063), branch_result=0 -> no outputs; branch_result=1 -> same response as the JAL case.
- LW with ex_rd=5, id_rs2=5, LOAD_STALL=1 -> stall=bubble=1 for 1 cycle, stall_count=1. Same with ex_rd=0 -> no stall.
- LOAD_STALL=3, JALR arrives in 2nd stall cycle -> stall drops that cycle, nop_enable high 2 cycles, stall_count=1, flush_count=1.
- hold=1 for 4 cycles mid-FLUSH -> nop_enable stays high throughout; total nop cycles = 2 + 4 held. rst pulse mid-FLUSH -> all outputs 0 next cycle and counters 0.
- CNT_W=2, 5 redirects -> flush_count sticks at 3.
